// File: rtl/gpio_irq_ctrl.sv
// Edge-detecting interrupt controller for GPIO banks 0, 1 and E.
// Latches synchronised rising edges into W1C pending registers and drives a level IRQ with bank id.
module gpio_irq_ctrl #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned IRQ_ID_BASE = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] gpio_0_in,
  input  logic [31:0] gpio_1_in,
  input  logic [7:0]  gpio_e_in,
  input  logic [2:0]  avs_address,
  input  logic        avs_read,
  input  logic        avs_write,
  input  logic [31:0] avs_writedata,
  output logic [31:0] avs_readdata,
  output logic        irq_o,
  output logic [4:0]  irq_id_o
);

  localparam int unsigned NumPins = 72;
  localparam logic [4:0] IdBank0 = 5'(IRQ_ID_BASE);
  localparam logic [4:0] IdBank1 = 5'(IRQ_ID_BASE + 1);
  localparam logic [4:0] IdBankE = 5'(IRQ_ID_BASE + 2);
  localparam logic [1:0] ArmCount = 2'(SYNC_STAGES);

  logic [NumPins-1:0] pins;
  logic [NumPins-1:0] sync_q [SYNC_STAGES];
  logic [NumPins-1:0] prev_q;
  logic [NumPins-1:0] rise;

  logic [1:0]  arm_cnt_q;
  logic        armed_q;

  logic [31:0] pend0_q, pend1_q, pend0_d, pend1_d;
  logic [7:0]  pende_q, pende_d;
  logic [31:0] mask0_q, mask1_q;
  logic [7:0]  maske_q;
  logic [31:0] w1c0, w1c1;
  logic [7:0]  w1ce;
  logic [2:0]  active;
  logic [31:0] rdata;

  assign pins = {gpio_e_in, gpio_1_in, gpio_0_in};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(SYNC_STAGES); i++) sync_q[i] <= '0;
      prev_q <= '0;
    end else begin
      sync_q[0] <= pins;
      for (int i = 1; i < int'(SYNC_STAGES); i++) sync_q[i] <= sync_q[i-1];
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  // Edges are ignored until the chain has flushed post-reset levels through prev_q.
  assign rise = sync_q[SYNC_STAGES-1] & ~prev_q & {NumPins{armed_q}};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      arm_cnt_q <= '0;
      armed_q   <= 1'b0;
    end else if (!armed_q) begin
      if (arm_cnt_q == ArmCount) armed_q <= 1'b1;
      else arm_cnt_q <= arm_cnt_q + 2'd1;
    end
  end

  always_comb begin
    w1c0 = '0;
    w1c1 = '0;
    w1ce = '0;
    if (avs_write) begin
      case (avs_address)
        3'd0:    w1c0 = avs_writedata;
        3'd1:    w1c1 = avs_writedata;
        3'd2:    w1ce = avs_writedata[7:0];
        default: ;
      endcase
    end
    // A rise in the same cycle as a clear wins.
    pend0_d = (pend0_q & ~w1c0) | rise[31:0];
    pend1_d = (pend1_q & ~w1c1) | rise[63:32];
    pende_d = (pende_q & ~w1ce) | rise[71:64];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend0_q <= '0;
      pend1_q <= '0;
      pende_q <= '0;
      mask0_q <= '0;
      mask1_q <= '0;
      maske_q <= '0;
    end else begin
      pend0_q <= pend0_d;
      pend1_q <= pend1_d;
      pende_q <= pende_d;
      if (avs_write) begin
        case (avs_address)
          3'd3:    mask0_q <= avs_writedata;
          3'd4:    mask1_q <= avs_writedata;
          3'd5:    maske_q <= avs_writedata[7:0];
          default: ;
        endcase
      end
    end
  end

  assign active = {|(pende_q & maske_q), |(pend1_q & mask1_q), |(pend0_q & mask0_q)};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      irq_o    <= 1'b0;
      irq_id_o <= '0;
    end else begin
      irq_o <= |active;
      if (active[0])      irq_id_o <= IdBank0;
      else if (active[1]) irq_id_o <= IdBank1;
      else if (active[2]) irq_id_o <= IdBankE;
    end
  end

  always_comb begin
    rdata = '0;
    case (avs_address)
      3'd0:    rdata = pend0_q;
      3'd1:    rdata = pend1_q;
      3'd2:    rdata = {24'd0, pende_q};
      3'd3:    rdata = mask0_q;
      3'd4:    rdata = mask1_q;
      3'd5:    rdata = {24'd0, maske_q};
      3'd6:    rdata = {19'd0, irq_id_o, 4'd0, active, irq_o};
      default: rdata = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)         avs_readdata <= '0;
    else if (avs_read) avs_readdata <= rdata;
  end

endmodule

// File: tb/tb_gpio_irq_ctrl.sv
// Scoreboard bench for gpio_irq_ctrl: a cycle model predicts irq, id and read data,
// a monitor on the falling edge pops and compares.
module tb_gpio_irq_ctrl;

  localparam int S = 2;
  localparam int Base = 3;

  logic        clk;
  logic        reset;
  logic [71:0] pins;
  logic [31:0] gpio_0_in, gpio_1_in;
  logic [7:0]  gpio_e_in;
  logic [2:0]  avs_address;
  logic        avs_read, avs_write;
  logic [31:0] avs_writedata, avs_readdata;
  logic        irq_o;
  logic [4:0]  irq_id_o;

  assign gpio_0_in = pins[31:0];
  assign gpio_1_in = pins[63:32];
  assign gpio_e_in = pins[71:64];

  gpio_irq_ctrl #(
    .SYNC_STAGES(S),
    .IRQ_ID_BASE(Base)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .gpio_0_in    (gpio_0_in),
    .gpio_1_in    (gpio_1_in),
    .gpio_e_in    (gpio_e_in),
    .avs_address  (avs_address),
    .avs_read     (avs_read),
    .avs_write    (avs_write),
    .avs_writedata(avs_writedata),
    .avs_readdata (avs_readdata),
    .irq_o        (irq_o),
    .irq_id_o     (irq_id_o)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  typedef struct packed {
    logic        irq;
    logic [4:0]  id;
    logic [31:0] rd;
  } exp_t;
  exp_t expq[$];

  // Reference model state
  logic [71:0] samples[$];
  int          k;
  logic [31:0] m_pend[3];
  logic [31:0] m_mask[3];
  logic        m_irq;
  logic [4:0]  m_id;
  logic [31:0] m_rd;

  function automatic logic [2:0] m_active();
    logic [2:0] a;
    for (int b = 0; b < 3; b++) a[b] = (m_pend[b] & m_mask[b]) != 0;
    return a;
  endfunction

  function automatic logic [31:0] m_reg(logic [2:0] addr);
    case (addr)
      3'd0, 3'd1, 3'd2: return m_pend[addr];
      3'd3, 3'd4, 3'd5: return m_mask[addr - 3'd3];
      3'd6:             return {19'd0, m_id, 4'd0, m_active(), m_irq};
      default:          return 32'd0;
    endcase
  endfunction

  initial begin : model
    forever begin
      @(posedge clk);
      if (reset) begin
        samples.delete();
        samples.push_back('0);
        k = 0;
        for (int b = 0; b < 3; b++) begin
          m_pend[b] = '0;
          m_mask[b] = '0;
        end
        m_irq = 1'b0;
        m_id  = '0;
        m_rd  = '0;
      end else begin
        logic [71:0] r;
        logic [2:0]  act;
        logic [31:0] clr;
        k++;
        samples.push_back(pins);
        if (avs_read) m_rd = m_reg(avs_address);
        act = m_active();
        // A pin sampled high at edge n, low at n-1, shows up as pending S edges later.
        r = '0;
        if (k >= S + 2) r = samples[k-S] & ~samples[k-S-1];
        for (int b = 0; b < 3; b++) begin
          clr = (avs_write && avs_address == 3'(b)) ? avs_writedata : 32'd0;
          m_pend[b] = m_pend[b] & ~clr;
        end
        m_pend[0] |= r[31:0];
        m_pend[1] |= r[63:32];
        m_pend[2] |= {24'd0, r[71:64]};
        if (avs_write && avs_address == 3'd3) m_mask[0] = avs_writedata;
        if (avs_write && avs_address == 3'd4) m_mask[1] = avs_writedata;
        if (avs_write && avs_address == 3'd5) m_mask[2] = {24'd0, avs_writedata[7:0]};
        m_irq = |act;
        if (act[0])      m_id = 5'(Base);
        else if (act[1]) m_id = 5'(Base + 1);
        else if (act[2]) m_id = 5'(Base + 2);
      end
      expq.push_back('{irq: m_irq, id: m_id, rd: m_rd});
    end
  end

  function automatic void check(string name, logic [31:0] got, logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h at %0t", name, got, exp, $time);
    end
  endfunction

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (expq.size() > 0) begin
        e = expq.pop_front();
        check("irq_o", 32'(irq_o), 32'(e.irq));
        check("irq_id_o", 32'(irq_id_o), 32'(e.id));
        check("avs_readdata", avs_readdata, e.rd);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    avs_read  = 1'b0;
    avs_write = 1'b0;
  endtask

  task automatic ticks(int n);
    repeat (n) tick();
  endtask

  task automatic wr(logic [2:0] a, logic [31:0] d);
    avs_write = 1'b1;
    avs_address = a;
    avs_writedata = d;
    tick();
  endtask

  task automatic rd(logic [2:0] a);
    avs_read = 1'b1;
    avs_address = a;
    tick();
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic pulse(int p, int len);
    pins[p] = 1'b1;
    ticks(len);
    pins[p] = 1'b0;
  endtask

  initial begin : driver
    reset = 1'b1;
    pins = '0;
    pins[5] = 1'b1;
    avs_address = '0;
    avs_read = 1'b0;
    avs_write = 1'b0;
    avs_writedata = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    // Pin high through reset must not latch
    ticks(10);
    rd(3'd0);
    rd(3'd6);

    wr(3'd3, 32'hFFFF_FFFF);
    wr(3'd4, 32'hFFFF_FFFF);
    wr(3'd5, 32'h0000_00FF);
    pulse(7, 2);
    ticks(4);
    rd(3'd0);
    wr(3'd0, 32'h80);
    ticks(2);

    // Bank priority: 1 ahead of E
    pins[71:64] = 8'h04;
    pins[63] = 1'b1;
    ticks(2);
    pins = '0;
    ticks(4);
    rd(3'd1);
    wr(3'd1, 32'h8000_0000);
    ticks(2);
    rd(3'd2);
    wr(3'd2, 32'h4);
    ticks(2);

    // Masked pending bit, then unmask
    wr(3'd4, 32'h0);
    pulse(32, 1);
    ticks(4);
    rd(3'd1);
    wr(3'd4, 32'h1);
    ticks(2);
    wr(3'd1, 32'h1);
    ticks(2);

    // New rise lands on the same edge as a W1C of that bit
    pulse(3, 1);
    ticks(4);
    pins[3] = 1'b1;
    ticks(2);
    wr(3'd0, 32'h8);
    rd(3'd0);
    pins[3] = 1'b0;
    ticks(2);
    wr(3'd0, 32'hFFFF_FFFF);
    ticks(2);

    // One rise per pin across all banks
    for (int p = 0; p < 72; p++) begin
      pulse(p, 1);
      ticks(4);
      rd(3'(p / 32));
      rd(3'd6);
      wr(3'(p / 32), 32'h1 << (p % 32));
      tick();
    end
    rd(3'd7);
    wr(3'd7, 32'hFFFF_FFFF);

    // Randomised traffic with a reset in the middle
    for (int i = 0; i < 2000; i++) begin
      int op;
      if (i == 1000) do_reset();
      if ($urandom_range(3) == 0) pins = pins ^ (72'd1 << $urandom_range(71));
      op = int'($urandom_range(5));
      if (op == 0) begin
        avs_read = 1'b1;
        avs_address = 3'($urandom_range(7));
      end else if (op == 1) begin
        avs_write = 1'b1;
        avs_address = 3'($urandom_range(7));
        avs_writedata = $urandom() & $urandom();
      end
      tick();
    end

    ticks(4);
    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
